// File: rtl/bt_speed_rx.sv
// UART receiver (8N1, or 8E1 when BT_SPEED_RX_PARITY_EN is defined) that turns ASCII
// speed commands from the Bluetooth link into a clamped 8-bit speed register.
`timescale 1ns/1ps
module bt_speed_rx #(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned BAUD       = 9600,
    parameter logic [7:0]  SPEED_MIN  = 8'd1,
    parameter logic [7:0]  SPEED_MAX  = 8'd8,
    parameter logic [7:0]  SPEED_INIT = 8'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_msg,
    output logic [7:0] speed,
    output logic       speed_valid,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       frame_err,
    output logic       parity_err
);
    localparam int unsigned DIV   = CLK_HZ / BAUD;
    localparam int unsigned CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef BT_SPEED_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_RECOVER
    } state_t;

    function automatic logic [7:0] f_clamp(input logic [7:0] v);
        if (v < SPEED_MIN) return SPEED_MIN;
        if (v > SPEED_MAX) return SPEED_MAX;
        return v;
    endfunction

    function automatic logic [7:0] f_decode(input logic [7:0] cur, input logic [7:0] b);
        if (b == 8'h2B) return (cur >= SPEED_MAX) ? SPEED_MAX : cur + 8'd1;
        if (b == 8'h2D) return (cur <= SPEED_MIN) ? SPEED_MIN : cur - 8'd1;
        if (b >= 8'h31 && b <= 8'h39) return f_clamp(b - 8'h30);
        if (b == 8'h30 || b == 8'h72) return SPEED_INIT;
        return cur;
    endfunction

    logic             r_sync_p0, r_sync_p1;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic [7:0]       r_rx_byte, r_speed;
    logic             r_rx_byte_valid, r_frame_err, r_speed_valid;
    logic             w_rxs, w_expire, w_byte_ok, w_ferr;
    logic [7:0]       w_speed_dec;
`ifdef BT_SPEED_RX_PARITY_EN
    logic             r_par_bad, w_par_nxt, r_parity_err, w_perr;
`endif

    assign w_rxs       = r_sync_p1;
    assign w_expire    = (r_cnt <= CNT_ONE);
    assign w_speed_dec = f_decode(r_speed, r_rx_byte);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_byte_ok   = 1'b0;
        w_ferr      = 1'b0;
`ifdef BT_SPEED_RX_PARITY_EN
        w_par_nxt   = r_par_bad;
        w_perr      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = CNT_HALF;
                end
            end
            S_START: begin
                if (!w_expire) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else if (!w_rxs) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = CNT_FULL;
                    w_bit_nxt   = 3'd0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (!w_expire) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else begin
                    w_shift_nxt = {w_rxs, r_shift[7:1]};
                    w_cnt_nxt   = CNT_FULL;
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
`ifdef BT_SPEED_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef BT_SPEED_RX_PARITY_EN
            S_PARITY: begin
                if (!w_expire) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else begin
                    // Even parity: data bits plus parity bit must XOR to zero.
                    w_par_nxt   = (^r_shift) ^ w_rxs;
                    w_cnt_nxt   = CNT_FULL;
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (!w_expire) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else begin
`ifdef BT_SPEED_RX_PARITY_EN
                    w_perr = r_par_bad;
`endif
                    if (w_rxs) begin
`ifdef BT_SPEED_RX_PARITY_EN
                        w_byte_ok = !r_par_bad;
`else
                        w_byte_ok = 1'b1;
`endif
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_RECOVER;
                    end
                end
            end
            S_RECOVER: begin
                if (w_rxs) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_p0       <= 1'b1;
            r_sync_p1       <= 1'b1;
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_bit           <= '0;
            r_shift         <= '0;
            r_rx_byte       <= '0;
            r_rx_byte_valid <= 1'b0;
            r_frame_err     <= 1'b0;
            r_speed         <= SPEED_INIT;
            r_speed_valid   <= 1'b0;
        end else begin
            r_sync_p0       <= in_msg;
            r_sync_p1       <= r_sync_p0;
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_bit           <= w_bit_nxt;
            r_shift         <= w_shift_nxt;
            r_rx_byte_valid <= w_byte_ok;
            r_frame_err     <= w_ferr;
            if (w_byte_ok) r_rx_byte <= r_shift;
            // Decode one cycle after the byte lands; pulse only on a real change.
            if (r_rx_byte_valid) begin
                r_speed       <= w_speed_dec;
                r_speed_valid <= (w_speed_dec != r_speed);
            end else begin
                r_speed_valid <= 1'b0;
            end
        end
    end

`ifdef BT_SPEED_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_par_bad    <= w_par_nxt;
            r_parity_err <= w_perr;
        end
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign speed         = r_speed;
    assign speed_valid   = r_speed_valid;
    assign rx_byte       = r_rx_byte;
    assign rx_byte_valid = r_rx_byte_valid;
    assign frame_err     = r_frame_err;
endmodule

// File: tb/tb_bt_speed_rx.sv
// Bench for bt_speed_rx: serial frames driven bit by bit, a vector table, hand-written
// corner sequences and a random command stream checked against a plain speed model.
`timescale 1ns/1ps
module tb_bt_speed_rx;
    localparam int DIV   = 16;
    localparam int SMIN  = 1;
    localparam int SMAX  = 8;
    localparam int SINIT = 2;
`ifdef BT_SPEED_RX_PARITY_EN
    localparam int LAT = 155 + DIV;
`else
    localparam int LAT = 155;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_msg = 1'b1;
    logic [7:0] speed, rx_byte;
    logic       speed_valid, rx_byte_valid, frame_err, parity_err;

    bt_speed_rx #(
        .CLK_HZ(16), .BAUD(1), .SPEED_MIN(8'd1), .SPEED_MAX(8'd8), .SPEED_INIT(8'd2)
    ) dut (
        .clk(clk), .rst(rst), .in_msg(in_msg),
        .speed(speed), .speed_valid(speed_valid),
        .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
        .frame_err(frame_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder, sampled on the falling edge.
    int n_rbv = 0, n_fe = 0, n_pe = 0, n_sv = 0, rbv_cyc = 0;
    logic [7:0] last_rx = 8'h00;
    always @(negedge clk) begin
        if (rx_byte_valid) begin
            n_rbv   = n_rbv + 1;
            last_rx = rx_byte;
            rbv_cyc = cyc;
        end
        if (frame_err)   n_fe = n_fe + 1;
        if (parity_err)  n_pe = n_pe + 1;
        if (speed_valid) n_sv = n_sv + 1;
    end

    int n_chk = 0, n_fail = 0;
    int m_speed = SINIT;

    task automatic check(input string name, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Speed rule model written straight from the command list.
    function automatic int ref_next(input int cur, input int b);
        int d;
        if (b == 43) return (cur < SMAX) ? cur + 1 : SMAX;
        if (b == 45) return (cur > SMIN) ? cur - 1 : SMIN;
        if (b >= 49 && b <= 57) begin
            d = b - 48;
            return (d < SMIN) ? SMIN : ((d > SMAX) ? SMAX : d);
        end
        if (b == 48 || b == 114) return SINIT;
        return cur;
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit bad_stop, input bit bad_par,
                              input int hold_low);
        in_msg = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            in_msg = b[i];
            tick(DIV);
        end
`ifdef BT_SPEED_RX_PARITY_EN
        in_msg = (^b) ^ bad_par;
        tick(DIV);
`endif
        in_msg = !bad_stop;
        tick(DIV);
        if (bad_stop) tick(hold_low);
        in_msg = 1'b1;
    endtask

    task automatic xfer(input logic [7:0] b, input bit bad_stop, input bit bad_par,
                        input int hold_low, input int gap, input int exp_spd,
                        input bit exp_sv, input string tag);
        int rb0, fe0, pe0, sv0, t0, lat;
        bit good;
        rb0 = n_rbv; fe0 = n_fe; pe0 = n_pe; sv0 = n_sv;
        t0 = cyc;
`ifdef BT_SPEED_RX_PARITY_EN
        good = !bad_stop && !bad_par;
`else
        good = !bad_stop;
`endif
        send_frame(b, bad_stop, bad_par, hold_low);
        tick(gap);
        check({tag, " rx_byte_valid count"}, n_rbv - rb0, good ? 1 : 0);
        if (good) begin
            check({tag, " rx_byte"}, int'(last_rx), int'(b));
            lat = rbv_cyc - t0;
            check({tag, " latency in window"}, (lat >= LAT - 4 && lat <= LAT + 4) ? 1 : 0, 1);
        end
        check({tag, " frame_err count"}, n_fe - fe0, bad_stop ? 1 : 0);
`ifdef BT_SPEED_RX_PARITY_EN
        check({tag, " parity_err count"}, n_pe - pe0, bad_par ? 1 : 0);
`else
        check({tag, " parity_err count"}, n_pe - pe0, 0);
`endif
        check({tag, " speed"}, int'(speed), exp_spd);
        check({tag, " speed_valid count"}, n_sv - sv0, exp_sv ? 1 : 0);
        m_speed = exp_spd;
    endtask

    typedef struct {
        logic [7:0] b;
        int         spd;
        bit         sv;
    } vec_t;
    vec_t tbl[$];

    initial begin
        int rb0, fe0, sv0, pe0, pick, exp, gap;
        logic [7:0] b;

        tbl.push_back('{8'h2B, 3, 1'b1});
        tbl.push_back('{8'h39, 8, 1'b1});
        tbl.push_back('{8'h2B, 8, 1'b0});
        for (int i = 0; i < 10; i++)
            tbl.push_back('{8'h2D, (i < 7) ? 7 - i : 1, (i < 7)});
        tbl.push_back('{8'h35, 5, 1'b1});
        tbl.push_back('{8'h35, 5, 1'b0});
        tbl.push_back('{8'h30, 2, 1'b1});
        tbl.push_back('{8'h41, 2, 1'b0});
        tbl.push_back('{8'h39, 8, 1'b1});
        tbl.push_back('{8'h72, 2, 1'b1});
        tbl.push_back('{8'h31, 1, 1'b1});
        tbl.push_back('{8'h2B, 2, 1'b1});
        tbl.push_back('{8'h35, 5, 1'b1});

        // Reset state and quiet idle line
        rst = 1'b1; in_msg = 1'b1;
        tick(3);
        check("reset speed", int'(speed), SINIT);
        check("reset rx_byte", int'(rx_byte), 0);
        check("reset pulses", {29'd0, speed_valid, rx_byte_valid, frame_err} | {31'd0, parity_err}, 0);
        rst = 1'b0;
        rb0 = n_rbv; fe0 = n_fe; sv0 = n_sv; pe0 = n_pe;
        tick(200);
        check("idle speed", int'(speed), SINIT);
        check("idle pulse count", (n_rbv - rb0) + (n_fe - fe0) + (n_sv - sv0) + (n_pe - pe0), 0);

        foreach (tbl[i])
            xfer(tbl[i].b, 1'b0, 1'b0, 0, (i % 3) * 5, tbl[i].spd, tbl[i].sv,
                 $sformatf("vec%0d", i));

        // Short low glitch must be rejected in the start-bit check
        rb0 = n_rbv; fe0 = n_fe;
        in_msg = 1'b0;
        tick(4);
        in_msg = 1'b1;
        tick(40);
        check("glitch rx_byte_valid", n_rbv - rb0, 0);
        check("glitch frame_err", n_fe - fe0, 0);

        // Broken stop bit followed by a long break, then a reset command
        xfer(8'h31, 1'b1, 1'b0, 100, 30, 5, 1'b0, "break");
        xfer(8'h72, 1'b0, 1'b0, 0, 3, 2, 1'b1, "after break");

        for (int k = 0; k < 60; k++) begin
            pick = $urandom_range(0, 7);
            case (pick)
                0, 1:    b = 8'h2B;
                2, 3:    b = 8'h2D;
                4, 5:    b = 8'(8'h30 + $urandom_range(0, 9));
                6:       b = 8'h72;
                default: b = 8'($urandom_range(0, 255));
            endcase
            gap = $urandom_range(0, 12);
            exp = ref_next(m_speed, int'(b));
            xfer(b, 1'b0, 1'b0, 0, gap, exp, exp != m_speed, $sformatf("rnd%0d", k));
        end

        // Reset in the middle of a data bit
        xfer(8'h37, 1'b0, 1'b0, 0, 2, 7, m_speed != 7, "pre-reset");
        rb0 = n_rbv; fe0 = n_fe;
        in_msg = 1'b0;
        tick(DIV);
        in_msg = 1'b1;
        tick(DIV * 3);
        rst = 1'b1;
        tick(1);
        check("midframe reset speed", int'(speed), SINIT);
        check("midframe reset rx_byte", int'(rx_byte), 0);
        rst = 1'b0;
        tick(40);
        check("midframe partial discarded", n_rbv - rb0, 0);
        check("midframe no frame_err", n_fe - fe0, 0);
        m_speed = SINIT;
        xfer(8'h2B, 1'b0, 1'b0, 0, 2, 3, 1'b1, "post-reset");

`ifdef BT_SPEED_RX_PARITY_EN
        xfer(8'h2B, 1'b0, 1'b1, 0, 4, 3, 1'b0, "bad parity");
        xfer(8'h2B, 1'b0, 1'b0, 0, 4, 4, 1'b1, "good parity");
        xfer(8'h2D, 1'b1, 1'b1, 20, 4, 4, 1'b0, "bad parity and stop");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
